// File: rtl/zircon_buzzer_pkg.sv
// Shared definitions for the Avalon buzzer sequencer: register offsets,
// FSM encoding and note-entry layout {divide[31:0], duration_ms[15:0]}.
package zircon_buzzer_pkg;

  localparam logic [1:0] ADDR_DIV  = 2'd0;
  localparam logic [1:0] ADDR_DUTY = 2'd1;
  localparam logic [1:0] ADDR_EN   = 2'd2;

  localparam int DIV_W   = 32;
  localparam int DUR_W   = 16;
  localparam int ENTRY_W = DIV_W + DUR_W;
  localparam int TICK_W  = 17;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WR_DIV  = 3'd2,
    ST_WR_DUTY = 3'd3,
    ST_WR_EN   = 3'd4,
    ST_HOLD    = 3'd5,
    ST_WR_OFF  = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  function automatic logic [DIV_W-1:0] entry_divide(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_W-1:DUR_W];
  endfunction

  function automatic logic [DUR_W-1:0] entry_duration(input logic [ENTRY_W-1:0] entry);
    return entry[DUR_W-1:0];
  endfunction

endpackage

// File: rtl/zircon_buzzer_note_rom.sv
// Synchronous note table; entry i lives at NOTE_TABLE[i*ENTRY_W +: ENTRY_W],
// read data appears one clock after the address.
module zircon_buzzer_note_rom
  import zircon_buzzer_pkg::*;
#(
  parameter int                            NOTE_COUNT = 16,
  parameter int                            IDX_W      = $clog2(NOTE_COUNT),
  parameter logic [NOTE_COUNT*ENTRY_W-1:0] NOTE_TABLE = {(NOTE_COUNT*ENTRY_W){1'b0}}
) (
  input  logic               clk,
  input  logic [IDX_W-1:0]   addr,
  output logic [ENTRY_W-1:0] data
);

  // registered table read
  always_ff @(posedge clk) begin
    data <= NOTE_TABLE[int'(addr)*ENTRY_W +: ENTRY_W];
  end

endmodule

// File: rtl/zircon_avalon_buzzer_sequencer.sv
// Plays a note table by programming a PWM buzzer peripheral over an
// Avalon-MM master port: divide, duty, enable per note, then a timed hold.
module zircon_avalon_buzzer_sequencer
  import zircon_buzzer_pkg::*;
#(
  parameter int                            NOTE_COUNT   = 16,
  parameter int                            TICKS_PER_MS = 50000,
  parameter logic [NOTE_COUNT*ENTRY_W-1:0] NOTE_TABLE   = {(NOTE_COUNT*ENTRY_W){1'b0}}
) (
  input  logic                          csi_clk,
  input  logic                          rsi_reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop_en,
  output logic [1:0]                    avm_address,
  output logic                          avm_write,
  output logic [31:0]                   avm_writedata,
  input  logic                          avm_waitrequest,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NOTE_COUNT)-1:0] note_index
);

  localparam int                IDX_W     = $clog2(NOTE_COUNT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NOTE_COUNT - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);

  state_t             state_r;
  state_t             state_nx_s;
  logic [IDX_W-1:0]   idx_r;
  logic               fetch_ph_r;
  logic [TICK_W-1:0]  tick_r;
  logic [DUR_W-1:0]   ms_r;
  logic               stop_pend_r;
  logic [ENTRY_W-1:0] entry_s;
  logic [DIV_W-1:0]   divide_s;
  logic [DUR_W-1:0]   duration_s;
  logic               xfer_done_s;
  logic               hold_exp_s;
  logic               in_wr_s;
  logic               stop_req_s;
  logic               wr_nx_s;
  logic [1:0]         addr_nx_s;
  logic [31:0]        data_nx_s;
  logic               avm_write_r;
  logic [1:0]         avm_address_r;
  logic [31:0]        avm_writedata_r;
  logic               busy_r;
  logic               done_r;

  zircon_buzzer_note_rom #(
    .NOTE_COUNT (NOTE_COUNT),
    .IDX_W      (IDX_W),
    .NOTE_TABLE (NOTE_TABLE)
  ) u_note_rom (
    .clk  (csi_clk),
    .addr (idx_r),
    .data (entry_s)
  );

  // The ROM address only moves on HOLD expiry or start, so its output is
  // stable from the second FETCH cycle until the note finishes.
  assign divide_s    = entry_divide(entry_s);
  assign duration_s  = entry_duration(entry_s);
  assign xfer_done_s = avm_write_r & ~avm_waitrequest;
  assign hold_exp_s  = (tick_r == TICK_LAST) && (ms_r == (duration_s - 16'd1));
  assign in_wr_s     = (state_r == ST_WR_DIV) || (state_r == ST_WR_DUTY) || (state_r == ST_WR_EN);
  assign stop_req_s  = stop | stop_pend_r;

  // state register
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) state_nx_s = ST_FETCH;
        else                state_nx_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (stop)                     state_nx_s = ST_WR_OFF;
        else if (!fetch_ph_r)         state_nx_s = ST_FETCH;
        else if (duration_s == 16'd0) state_nx_s = ST_WR_OFF;
        else if (divide_s == 32'd0)   state_nx_s = ST_WR_EN;
        else                          state_nx_s = ST_WR_DIV;
      end
      ST_WR_DIV: begin
        if (!xfer_done_s)    state_nx_s = ST_WR_DIV;
        else if (stop_req_s) state_nx_s = ST_WR_OFF;
        else                 state_nx_s = ST_WR_DUTY;
      end
      ST_WR_DUTY: begin
        if (!xfer_done_s)    state_nx_s = ST_WR_DUTY;
        else if (stop_req_s) state_nx_s = ST_WR_OFF;
        else                 state_nx_s = ST_WR_EN;
      end
      ST_WR_EN: begin
        if (!xfer_done_s)    state_nx_s = ST_WR_EN;
        else if (stop_req_s) state_nx_s = ST_WR_OFF;
        else                 state_nx_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop)                             state_nx_s = ST_WR_OFF;
        else if (!hold_exp_s)                 state_nx_s = ST_HOLD;
        else if (idx_r != LAST_IDX || loop_en) state_nx_s = ST_FETCH;
        else                                  state_nx_s = ST_WR_OFF;
      end
      ST_WR_OFF: begin
        if (xfer_done_s) state_nx_s = ST_DONE;
        else             state_nx_s = ST_WR_OFF;
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // bus command for the state being entered
  always_comb begin
    wr_nx_s   = 1'b0;
    addr_nx_s = 2'd0;
    data_nx_s = 32'd0;
    case (state_nx_s)
      ST_WR_DIV: begin
        wr_nx_s   = 1'b1;
        addr_nx_s = ADDR_DIV;
        data_nx_s = divide_s;
      end
      ST_WR_DUTY: begin
        wr_nx_s   = 1'b1;
        addr_nx_s = ADDR_DUTY;
        data_nx_s = divide_s >> 1;
      end
      ST_WR_EN: begin
        wr_nx_s   = 1'b1;
        addr_nx_s = ADDR_EN;
        data_nx_s = (divide_s == 32'd0) ? 32'd0 : 32'd1;
      end
      ST_WR_OFF: begin
        wr_nx_s   = 1'b1;
        addr_nx_s = ADDR_EN;
        data_nx_s = 32'd0;
      end
      default: begin
        wr_nx_s   = 1'b0;
        addr_nx_s = 2'd0;
        data_nx_s = 32'd0;
      end
    endcase
  end

  // Bus outputs load only on a state change, which keeps them frozen
  // through any waitrequest stall.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      avm_write_r     <= 1'b0;
      avm_address_r   <= 2'd0;
      avm_writedata_r <= 32'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      done_r <= (state_nx_s == ST_DONE);
      if (state_nx_s != state_r) begin
        avm_write_r     <= wr_nx_s;
        avm_address_r   <= addr_nx_s;
        avm_writedata_r <= data_nx_s;
      end
    end
  end

  // note index, fetch phase, hold timer and pending-stop latch
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      idx_r       <= {IDX_W{1'b0}};
      fetch_ph_r  <= 1'b0;
      tick_r      <= {TICK_W{1'b0}};
      ms_r        <= 16'd0;
      stop_pend_r <= 1'b0;
    end else begin
      fetch_ph_r <= (state_r == ST_FETCH) && (state_nx_s == ST_FETCH);

      if (state_r == ST_IDLE && state_nx_s == ST_FETCH) begin
        idx_r <= {IDX_W{1'b0}};
      end else if (state_r == ST_HOLD && hold_exp_s && !stop) begin
        idx_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end

      if (state_r == ST_HOLD && state_nx_s == ST_HOLD) begin
        if (tick_r == TICK_LAST) begin
          tick_r <= {TICK_W{1'b0}};
          ms_r   <= ms_r + 16'd1;
        end else begin
          tick_r <= tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
        end
      end else begin
        tick_r <= {TICK_W{1'b0}};
        ms_r   <= 16'd0;
      end

      if (state_nx_s == ST_IDLE) begin
        stop_pend_r <= 1'b0;
      end else if (in_wr_s && stop) begin
        stop_pend_r <= 1'b1;
      end
    end
  end

  assign avm_write     = avm_write_r;
  assign avm_address   = avm_address_r;
  assign avm_writedata = avm_writedata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign note_index    = idx_r;

endmodule

// File: tb/tb_zircon_avalon_buzzer_sequencer.sv
// Bench: two sequencer instances (terminated table / looping table) driven in
// turn, writes scored against a table-walking reference model.
module tb_zircon_avalon_buzzer_sequencer;

  localparam int NC  = 4;
  localparam int TPM = 4;
  localparam logic [NC*48-1:0] TABLE_A = {32'd777, 16'd0, 32'd500, 16'd1, 32'd0, 16'd1, 32'd1000, 16'd2};
  localparam logic [NC*48-1:0] TABLE_B = {32'd300, 16'd1, 32'd600, 16'd2, 32'd0, 16'd1, 32'd1000, 16'd1};

  int unsigned ref_div [2][NC] = '{'{1000, 0, 500, 777}, '{1000, 0, 600, 300}};
  int unsigned ref_dur [2][NC] = '{'{2, 1, 1, 0},        '{1, 1, 2, 1}};

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          gap;
    int          sc;
  } wr_t;

  logic clk = 1'b0;
  logic rst, start, stop, loop_en, sel;
  logic wreq = 1'b0;

  logic [1:0]  a_addr, b_addr, m_addr;
  logic [31:0] a_data, b_data, m_data;
  logic        a_write, b_write, m_write;
  logic        a_busy, b_busy, m_busy;
  logic        a_done, b_done, m_done;
  logic [1:0]  a_idx, b_idx, m_idx;

  always #5 clk = ~clk;

  zircon_avalon_buzzer_sequencer #(.NOTE_COUNT(NC), .TICKS_PER_MS(TPM), .NOTE_TABLE(TABLE_A)) dut_a (
    .csi_clk(clk), .rsi_reset(rst), .start(start & ~sel), .stop(stop & ~sel), .loop_en(loop_en),
    .avm_address(a_addr), .avm_write(a_write), .avm_writedata(a_data), .avm_waitrequest(wreq),
    .busy(a_busy), .done(a_done), .note_index(a_idx));

  zircon_avalon_buzzer_sequencer #(.NOTE_COUNT(NC), .TICKS_PER_MS(TPM), .NOTE_TABLE(TABLE_B)) dut_b (
    .csi_clk(clk), .rsi_reset(rst), .start(start & sel), .stop(stop & sel), .loop_en(loop_en),
    .avm_address(b_addr), .avm_write(b_write), .avm_writedata(b_data), .avm_waitrequest(wreq),
    .busy(b_busy), .done(b_done), .note_index(b_idx));

  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_data  = sel ? b_data  : a_data;
  assign m_write = sel ? b_write : a_write;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_idx   = sel ? b_idx   : a_idx;

  int vectors = 0, miscompares = 0;
  wr_t got_q[$];
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor / slave model: picks stalls, records completed writes with the
  // idle gap (cycles) since the previous completion or accepted start.
  int cyc = 0, ref_cyc = 0, last_cpl = 0, done_cnt = 0, done_cyc = 0;
  int stall_left = 0, stall_mode = 0, w_start = 0, stop_cyc = 0;
  logic in_xfer = 1'b0;
  logic done_busy_bad = 1'b0;
  logic [1:0]  h_addr;
  logic [31:0] h_data;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_xfer    = 1'b0;
      stall_left = 0;
      wreq       = 1'b0;
    end else begin
      if (start && !m_busy) ref_cyc = cyc;
      if (stop) stop_cyc = cyc;
      if (m_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!m_busy) done_busy_bad = 1'b1;
      end
      if (m_write) begin
        if (!in_xfer) begin
          in_xfer    = 1'b1;
          h_addr     = m_addr;
          h_data     = m_data;
          w_start    = cyc;
          stall_left = (stall_mode == 0) ? 0 : (stall_mode == 1) ? 3 : int'($urandom_range(0, 3));
        end else begin
          check("stall_addr_stable", m_addr, h_addr);
          check("stall_data_stable", m_data, h_data);
        end
        wreq = (stall_left != 0);
        if (stall_left != 0) begin
          stall_left--;
        end else begin
          got_q.push_back('{m_addr, m_data, w_start - ref_cyc - 1, w_start});
          ref_cyc  = cyc;
          last_cpl = cyc;
          in_xfer  = 1'b0;
        end
      end else begin
        if (in_xfer) begin
          check("write_held_in_stall", m_write, 1'b1);
          in_xfer = 1'b0;
        end
        wreq = (stall_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (m_busy && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_reaches_idle"}, m_busy, 1'b0);
  endtask

  // Reference: walk the table; gap before a note is 2 fetch cycles (after the
  // previous hold), a direct switch-off after the last note has no fetch.
  task automatic build_exp(input int t, input bit lp, input int max_notes);
    int idx = 0, gap = 2, notes = 0, hold;
    exp_q.delete();
    while (1'b1) begin
      if (ref_dur[t][idx] == 0) begin
        exp_q.push_back('{2'd2, 32'd0, gap, 0});
        return;
      end
      if (ref_div[t][idx] == 0) begin
        exp_q.push_back('{2'd2, 32'd0, gap, 0});
      end else begin
        exp_q.push_back('{2'd0, ref_div[t][idx], gap, 0});
        exp_q.push_back('{2'd1, ref_div[t][idx] / 2, 0, 0});
        exp_q.push_back('{2'd2, 32'd1, 0, 0});
      end
      notes++;
      if (notes == max_notes) return;
      hold = int'(ref_dur[t][idx]) * TPM;
      if (idx == NC - 1 && !lp) begin
        exp_q.push_back('{2'd2, 32'd0, hold, 0});
        return;
      end
      idx = (idx + 1) % NC;
      gap = hold + 2;
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_write_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_addr[%0d]", tag, i), got_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_data[%0d]", tag, i), got_q[i].data, exp_q[i].data);
      if (exp_q[i].gap >= 0) check($sformatf("%s_gap[%0d]", tag, i), got_q[i].gap, exp_q[i].gap);
    end
  endtask

  task automatic run_table(input bit s, input bit lp, input int smode, input bit restart, input string tag);
    int d0;
    sel = s; loop_en = lp; stall_mode = smode;
    got_q.delete();
    build_exp(s, lp, 1000);
    d0 = done_cnt;
    done_busy_bad = 1'b0;
    pulse_start();
    if (restart) begin
      repeat (5) tick();
      pulse_start();
    end
    wait_idle(tag);
    compare_writes(tag);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_done_after_off"}, done_cyc, last_cpl + 1);
    check({tag, "_busy_during_done"}, done_busy_bad, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; sel = 1'b0;
    repeat (3) tick();
    check("rst_write", m_write, 1'b0);
    check("rst_addr", m_addr, 2'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_busy", m_busy, 1'b0);
    check("rst_done", m_done, 1'b0);
    check("rst_index", m_idx, 2'd0);
    rst = 1'b0;
    tick();

    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_with_stop_stays_idle", m_busy, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_in_idle_no_effect", m_busy, 1'b0);

    run_table(1'b0, 1'b0, 0, 1'b0, "basic");
    run_table(1'b0, 1'b0, 1, 1'b0, "stall3");
    run_table(1'b0, 1'b0, 0, 1'b1, "start_while_busy");
    for (int i = 0; i < 4; i++) run_table(i[0], 1'b0, 2, 1'b0, $sformatf("rand%0d", i));

    // looping table, stop during the second pass of entry 0
    sel = 1'b1; loop_en = 1'b1; stall_mode = 0;
    got_q.delete();
    build_exp(1, 1'b1, 5);
    exp_q.push_back('{2'd2, 32'd0, -1, 0});
    pulse_start();
    n = 0;
    while (got_q.size() < 13 && n < 500) begin
      tick();
      n++;
    end
    check("loop_writes_before_stop", got_q.size(), 13);
    check("loop_index_wrapped", m_idx, 2'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("loop_stop");
    compare_writes("loop_stop");
    if (got_q.size() > 13) check("loop_stop_latency", got_q[13].sc, stop_cyc + 1);
    loop_en = 1'b0;

    // stop while WR_DUTY is stalled
    sel = 1'b0; stall_mode = 1;
    got_q.delete();
    exp_q.delete();
    exp_q.push_back('{2'd0, 32'd1000, 2, 0});
    exp_q.push_back('{2'd1, 32'd500, 0, 0});
    exp_q.push_back('{2'd2, 32'd0, 0, 0});
    pulse_start();
    n = 0;
    while (!(m_write && m_addr == 2'd1) && n < 200) begin
      tick();
      n++;
    end
    check("duty_write_seen", m_write, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("stop_in_duty");
    compare_writes("stop_in_duty");

    // reset while WR_DIV is stalled, then replay
    stall_mode = 1;
    got_q.delete();
    pulse_start();
    n = 0;
    while (!(m_write && m_addr == 2'd0) && n < 200) begin
      tick();
      n++;
    end
    check("div_write_seen", m_write, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_write", m_write, 1'b0);
    check("mid_rst_addr", m_addr, 2'd0);
    check("mid_rst_data", m_data, 32'd0);
    check("mid_rst_busy", m_busy, 1'b0);
    check("mid_rst_index", m_idx, 2'd0);
    tick();
    tick();
    check("rst_no_off_write", got_q.size(), 0);
    rst = 1'b0;
    stall_mode = 2;
    got_q.delete();
    build_exp(0, 1'b0, 1000);
    pulse_start();
    check("start_after_rst_accepted", m_busy, 1'b1);
    wait_idle("replay");
    compare_writes("replay");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
